ad7606_ch_avg: RTL and testbench

//  Downstream of the AD7606 parallel-read controller. Takes the per-channel 16-bit samples it reads out.

---
 rtl/ad7606_pkg.sv | 15 +
 rtl/ad7606_ch_avg.sv | 168 ++++++++++++++++
 tb/tb_ad7606_ch_avg.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/ad7606_pkg.sv
// Shared AD7606 types: sample/channel widths used by the controller, averager and DA stages.
package ad7606_pkg;

    localparam int AD_SAMPLE_W   = 16;
    localparam int AD_NUM_CH_MAX = 8;

    typedef logic signed [AD_SAMPLE_W-1:0] ad_sample_t;
    typedef logic [2:0]                    ad_ch_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } ad_avg_state_t;

endpackage

// File: rtl/ad7606_ch_avg.sv
// Per-channel boxcar averager of 2**AVG_LOG2 AD7606 frames, drained as a valid/ready stream.
// Define AD_AVG_ROUND_EN for round-half-up with saturation instead of floor truncation.
module ad7606_ch_avg
    import ad7606_pkg::*;
#(
    parameter int NUM_CH   = 8,
    parameter int AVG_LOG2 = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    input  ad_sample_t s_data,
    input  logic       s_first,
    output logic       m_valid,
    input  logic       m_ready,
    output ad_sample_t m_data,
    output ad_ch_t     m_ch,
    output logic       m_last,
    output logic       frame_err,
    output logic       ovf
);

    localparam int ACC_W = AD_SAMPLE_W + AVG_LOG2;
    localparam int CI_W  = $clog2(NUM_CH + 1);
    localparam int FC_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    localparam logic [CI_W-1:0] END_CI  = CI_W'(NUM_CH);
    localparam logic [CI_W-1:0] LAST_CI = CI_W'(NUM_CH - 1);
    localparam ad_ch_t          LAST_RD = ad_ch_t'(NUM_CH - 1);
    localparam logic [FC_W-1:0] FC_MAX  = FC_W'((1 << AVG_LOG2) - 1);

    localparam logic signed [ACC_W:0] RND_ADD = (ACC_W+1)'((1 << AVG_LOG2) >> 1);
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(32767);

    typedef logic signed [ACC_W-1:0] acc_t;

    function automatic ad_sample_t scale(input acc_t a);
        logic signed [ACC_W:0] t;
        logic signed [ACC_W:0] s;
`ifdef AD_AVG_ROUND_EN
        t = {a[ACC_W-1], a} + RND_ADD;
        s = t >>> AVG_LOG2;
        if (s > SAT_MAX)
            return 16'sh7FFF;
        return ad_sample_t'(s);
`else
        t = {a[ACC_W-1], a};
        s = t >>> AVG_LOG2;
        return ad_sample_t'(s);
`endif
    endfunction

    acc_t            acc     [NUM_CH];
    acc_t            acc_nxt [NUM_CH];
    ad_sample_t      res     [NUM_CH];
    logic [CI_W-1:0] ch_idx, ch_idx_nxt;
    logic [FC_W-1:0] frame_cnt, fc_nxt;
    logic            err_nxt, batch_done, load, last_hs;
    ad_avg_state_t   state, state_nxt;
    ad_ch_t          rd_idx, rd_nxt;
    acc_t            smp_ext;

    assign smp_ext = acc_t'(s_data);

    // Channel tracking, framing checks and accumulation for the incoming sample.
    always_comb begin
        acc_nxt    = acc;
        ch_idx_nxt = ch_idx;
        fc_nxt     = frame_cnt;
        err_nxt    = 1'b0;
        batch_done = 1'b0;
        if (s_valid) begin
            if (s_first) begin
                if (ch_idx != '0 && ch_idx != END_CI) begin
                    err_nxt = 1'b1;
                    fc_nxt  = '0;
                    for (int c = 0; c < NUM_CH; c++)
                        acc_nxt[c] = '0;
                end
                acc_nxt[0] = acc_nxt[0] + smp_ext;
                ch_idx_nxt = CI_W'(1);
            end else if (ch_idx == '0 || ch_idx == END_CI) begin
                err_nxt = 1'b1;
            end else begin
                for (int c = 0; c < NUM_CH; c++)
                    if (ch_idx == CI_W'(c))
                        acc_nxt[c] = acc_nxt[c] + smp_ext;
                ch_idx_nxt = ch_idx + 1'b1;
                if (ch_idx == LAST_CI) begin
                    if (frame_cnt == FC_MAX)
                        batch_done = 1'b1;
                    else
                        fc_nxt = frame_cnt + 1'b1;
                end
            end
        end
    end

    // A drain finishing in the same cycle frees the bank for the new batch.
    assign last_hs = (state == ST_DRAIN) && m_ready && (rd_idx == LAST_RD);
    assign load    = batch_done && ((state == ST_IDLE) || last_hs);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                acc[c] <= '0;
                res[c] <= '0;
            end
            ch_idx    <= '0;
            frame_cnt <= '0;
            frame_err <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            ch_idx    <= ch_idx_nxt;
            frame_err <= err_nxt;
            ovf       <= batch_done && !load;
            if (batch_done) begin
                frame_cnt <= '0;
                for (int c = 0; c < NUM_CH; c++)
                    acc[c] <= '0;
            end else begin
                frame_cnt <= fc_nxt;
                for (int c = 0; c < NUM_CH; c++)
                    acc[c] <= acc_nxt[c];
            end
            if (load)
                for (int c = 0; c < NUM_CH; c++)
                    res[c] <= scale(acc_nxt[c]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            rd_idx <= '0;
        end else begin
            state  <= state_nxt;
            rd_idx <= rd_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_nxt    = rd_idx;
        m_valid   = 1'b0;
        m_last    = 1'b0;
        m_ch      = rd_idx;
        m_data    = '0;
        if (state == ST_DRAIN) begin
            m_valid = 1'b1;
            m_last  = (rd_idx == LAST_RD);
            if (m_ready) begin
                if (rd_idx == LAST_RD)
                    state_nxt = ST_IDLE;
                else
                    rd_nxt = rd_idx + 1'b1;
            end
        end
        for (int c = 0; c < NUM_CH; c++)
            if (rd_idx == ad_ch_t'(c))
                m_data = res[c];
        if (load) begin
            state_nxt = ST_DRAIN;
            rd_nxt    = '0;
        end
    end

endmodule

// File: tb/tb_ad7606_ch_avg.sv
// Directed bench for ad7606_ch_avg (NUM_CH=8, AVG_LOG2=2) with hand-computed averages.
module tb_ad7606_ch_avg;

    localparam int NUM_CH   = 8;
    localparam int AVG_LOG2 = 2;

    logic              clk = 1'b0;
    logic              rst, s_valid, s_first, m_valid, m_ready, m_last, frame_err, ovf;
    logic signed [15:0] s_data, m_data;
    logic [2:0]        m_ch;

    int n_chk  = 0;
    int n_fail = 0;
    int n_err  = 0;
    int n_ovf  = 0;
    int rd     = 0;
    int fv [8];
    int ex [8];
    int eb, ob;

    logic signed [15:0] q_data [$];
    logic [2:0]         q_ch   [$];
    logic               q_last [$];

    ad7606_ch_avg #(.NUM_CH(NUM_CH), .AVG_LOG2(AVG_LOG2)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_first(s_first),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_ch(m_ch),
        .m_last(m_last), .frame_err(frame_err), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Handshakes are recorded mid-cycle, just before the edge that completes them.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            q_data.push_back(m_data);
            q_ch.push_back(m_ch);
            q_last.push_back(m_last);
        end
        if (frame_err) n_err++;
        if (ovf)       n_ovf++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int d, input logic f);
        s_valid = 1'b1;
        s_data  = 16'(d);
        s_first = f;
        cyc();
        s_valid = 1'b0;
        s_first = 1'b0;
    endtask

    task automatic send_frame();
        for (int k = 0; k < NUM_CH; k++)
            send(fv[k], k == 0);
    endtask

    task automatic send_batch();
        repeat (1 << AVG_LOG2) send_frame();
    endtask

    task automatic check_drain(input string tag);
        int t = 0;
        while (q_data.size() < rd + NUM_CH && t < 200) begin
            cyc();
            t++;
        end
        chk({tag, ".count"}, q_data.size() >= rd + NUM_CH, 1);
        if (q_data.size() >= rd + NUM_CH) begin
            for (int k = 0; k < NUM_CH; k++) begin
                chk($sformatf("%s.data%0d", tag, k), q_data[rd+k], ex[k]);
                chk($sformatf("%s.ch%0d", tag, k), q_ch[rd+k], k);
                chk($sformatf("%s.last%0d", tag, k), q_last[rd+k], k == NUM_CH-1);
            end
            rd += NUM_CH;
        end
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_first = 1'b0; s_data = '0; m_ready = 1'b0;
        cyc(3);
        chk("rst.m_valid", m_valid, 0);
        chk("rst.m_data", m_data, 0);
        chk("rst.m_ch", m_ch, 0);
        chk("rst.m_last", m_last, 0);
        chk("rst.frame_err", frame_err, 0);
        chk("rst.ovf", ovf, 0);
        rst = 1'b0;
        cyc();

        // 1: basic average
        m_ready = 1'b1; eb = n_err; ob = n_ovf;
        for (int k = 0; k < NUM_CH; k++) begin fv[k] = 100*k; ex[k] = 100*k; end
        send_batch();
        chk("t1.latency", m_valid, 1);
        check_drain("t1");
        cyc(5);
        chk("t1.idle", m_valid, 0);
        chk("t1.err", n_err - eb, 0);
        chk("t1.ovf", n_ovf - ob, 0);

        // 2: sign and rounding
        eb = n_err; ob = n_ovf;
        for (int k = 0; k < NUM_CH; k++) begin fv[k] = 0; ex[k] = 0; end
        fv[0] = -3; fv[1] = 1;
        repeat (3) send_frame();
        fv[0] = -2; fv[1] = 0;
        send_frame();
        ex[0] = -3;
`ifdef AD_AVG_ROUND_EN
        ex[1] = 1;
`else
        ex[1] = 0;
`endif
        check_drain("t2");
        chk("t2.err", n_err - eb, 0);
        chk("t2.ovf", n_ovf - ob, 0);

        // 3: backpressure
        m_ready = 1'b0; eb = n_err; ob = n_ovf;
        for (int k = 0; k < NUM_CH; k++) begin fv[k] = 7 - 50*k; ex[k] = fv[k]; end
        send_batch();
        for (int i = 0; i < 20; i++) begin
            chk("t3.hold_valid", m_valid, 1);
            chk("t3.hold_data", m_data, ex[0]);
            chk("t3.hold_ch", m_ch, 0);
            cyc();
        end
        m_ready = 1'b1;
        check_drain("t3");
        chk("t3.err", n_err - eb, 0);
        chk("t3.ovf", n_ovf - ob, 0);

        // 4: overflow while draining is stalled
        m_ready = 1'b0; eb = n_err; ob = n_ovf;
        for (int k = 0; k < NUM_CH; k++) begin fv[k] = 20*k + 3; ex[k] = fv[k]; end
        send_batch();
        for (int k = 0; k < NUM_CH; k++) fv[k] = fv[k] + 1;
        send_batch();
        cyc();
        chk("t4.ovf", n_ovf - ob, 1);
        m_ready = 1'b1;
        check_drain("t4");
        cyc(12);
        chk("t4.no_second", q_data.size(), rd);
        chk("t4.err", n_err - eb, 0);

        // 5: early s_first resync, then a stray ninth sample
        eb = n_err; ob = n_ovf;
        for (int k = 0; k < NUM_CH; k++) fv[k] = 999;
        send_frame();
        for (int k = 0; k < 3; k++) send(999, k == 0);
        for (int k = 0; k < NUM_CH; k++) begin fv[k] = 7*k - 20; ex[k] = fv[k]; end
        send_batch();
        chk("t5.resync_err", n_err - eb, 1);
        check_drain("t5a");
        eb = n_err;
        send_frame();
        send(5000, 1'b0);
        repeat (3) send_frame();
        chk("t5.ninth_err", n_err - eb, 1);
        check_drain("t5b");
        chk("t5.ovf", n_ovf - ob, 0);

        // 6: reset mid-drain, then unsynced sample, then a clean batch
        m_ready = 1'b0;
        for (int k = 0; k < NUM_CH; k++) fv[k] = 300 - 11*k;
        send_batch();
        m_ready = 1'b1;
        cyc(4);
        m_ready = 1'b0;
        chk("t6.rd4_ch", m_ch, 4);
        chk("t6.rd4_valid", m_valid, 1);
        rd += 4;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t6.rst_valid", m_valid, 0);
        chk("t6.rst_ch", m_ch, 0);
        m_ready = 1'b1;
        cyc(3);
        chk("t6.no_out", q_data.size(), rd);
        eb = n_err; ob = n_ovf;
        send(1234, 1'b0);
        cyc();
        chk("t6.nosync_err", n_err - eb, 1);
        for (int k = 0; k < NUM_CH; k++) begin fv[k] = 250*k - 1000; ex[k] = fv[k]; end
        send_batch();
        check_drain("t6");
        chk("t6.ovf", n_ovf - ob, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
